// File: rtl/clock_mode_controller.sv
// Mode/edit controller for a 12-hour alarm clock with a background stopwatch.
// Optional build macro SNOOZE_EN adds a snooze re-ring timer to the alarm path.
module clock_mode_controller (
    input  logic       clock_sec,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    input  logic [3:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic       cur_am_pm,
    input  logic       alarm_ringing,
    output logic       set_time,
    output logic [3:0] set_hour,
    output logic [5:0] set_minute,
    output logic       set_am_pm,
    output logic [3:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_am_pm,
    output logic       stopwatch_on,
    output logic       stopwatch_reset,
    output logic [2:0] mode,
    output logic       alarm_armed,
    output logic       alarm_out
);

    typedef enum logic [2:0] {
        RUN           = 3'd0,
        EDIT_HOUR     = 3'd1,
        EDIT_MIN      = 3'd2,
        EDIT_ALM_HOUR = 3'd3,
        EDIT_ALM_MIN  = 3'd4,
        STOPWATCH     = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] btn_vec, btn_prev_reg, press;
    logic       mode_press, inc_act, clr_act;
    logic       in_run, in_sw, edit_hr, edit_min, edit_alm_hr, edit_alm_min;

    logic       set_time_reg, stopwatch_reset_reg, stopwatch_on_reg;
    logic [3:0] set_hour_reg, alarm_hour_reg;
    logic [5:0] set_minute_reg, alarm_minute_reg;
    logic       set_am_pm_reg, alarm_am_pm_reg;
    logic       alarm_armed_reg, alarm_armed_next;
    logic       silenced_reg, silenced_next;
    logic       alarm_out_reg, alarm_out_next;
    logic       silence_press, snooze_force;

    function automatic logic [3:0] next_hour(input logic [3:0] h);
        return (h == 4'd12) ? 4'd1 : h + 4'd1;
    endfunction

    function automatic logic [5:0] next_minute(input logic [5:0] m);
        return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    // Rising-edge press detect, one lane per button: {clr, inc, mode}
    assign btn_vec = {btn_clr, btn_inc, btn_mode};
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_press
            assign press[gi] = btn_vec[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    assign mode_press = press[0];
    assign inc_act    = press[1] & ~mode_press;
    assign clr_act    = press[2] & ~mode_press;

    always_ff @(posedge clock_sec or posedge reset) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (mode_press) begin
            case (state_reg)
                RUN:           state_next = EDIT_HOUR;
                EDIT_HOUR:     state_next = EDIT_MIN;
                EDIT_MIN:      state_next = EDIT_ALM_HOUR;
                EDIT_ALM_HOUR: state_next = EDIT_ALM_MIN;
                EDIT_ALM_MIN:  state_next = STOPWATCH;
                default:       state_next = RUN;
            endcase
        end
    end

    always_comb begin
        mode         = state_reg;
        in_run       = (state_reg == RUN);
        in_sw        = (state_reg == STOPWATCH);
        edit_hr      = (state_reg == EDIT_HOUR);
        edit_min     = (state_reg == EDIT_MIN);
        edit_alm_hr  = (state_reg == EDIT_ALM_HOUR);
        edit_alm_min = (state_reg == EDIT_ALM_MIN);
    end

    assign silence_press = in_run & inc_act & alarm_out_reg;

`ifdef SNOOZE_EN
    logic [8:0] snooze_cnt_reg, snooze_cnt_next;
    logic [5:0] ring_cnt_reg, ring_cnt_next;
    logic       snooze_wait_reg, snooze_wait_next;
    logic       snooze_ring_reg, snooze_ring_next;

    // Wait 300 cycles after a silence press, then force the buzzer for up to 60 cycles
    always_comb begin
        snooze_cnt_next  = snooze_cnt_reg;
        ring_cnt_next    = ring_cnt_reg;
        snooze_wait_next = snooze_wait_reg;
        snooze_ring_next = snooze_ring_reg;
        if (silence_press) begin
            snooze_wait_next = 1'b1;
            snooze_ring_next = 1'b0;
            snooze_cnt_next  = 9'd299;
        end else if (clr_act) begin
            snooze_wait_next = 1'b0;
            snooze_ring_next = 1'b0;
        end else if (snooze_wait_reg) begin
            if (snooze_cnt_reg == 9'd0) begin
                snooze_wait_next = 1'b0;
                snooze_ring_next = 1'b1;
                ring_cnt_next    = 6'd0;
            end else begin
                snooze_cnt_next = snooze_cnt_reg - 9'd1;
            end
        end else if (snooze_ring_reg) begin
            if (inc_act || ring_cnt_reg == 6'd59) snooze_ring_next = 1'b0;
            else                                  ring_cnt_next = ring_cnt_reg + 6'd1;
        end
    end

    always_ff @(posedge clock_sec or posedge reset) begin
        if (reset) begin
            snooze_cnt_reg  <= 9'd0;
            ring_cnt_reg    <= 6'd0;
            snooze_wait_reg <= 1'b0;
            snooze_ring_reg <= 1'b0;
        end else begin
            snooze_cnt_reg  <= snooze_cnt_next;
            ring_cnt_reg    <= ring_cnt_next;
            snooze_wait_reg <= snooze_wait_next;
            snooze_ring_reg <= snooze_ring_next;
        end
    end

    assign snooze_force = snooze_ring_next;
`else
    assign snooze_force = 1'b0;
`endif

    // Gate on post-edge arm/silence state so a silence press drops the buzzer at once
    always_comb begin
        alarm_armed_next = alarm_armed_reg ^ (in_run & clr_act);
        silenced_next    = silenced_reg;
        if (!alarm_ringing)     silenced_next = 1'b0;
        else if (silence_press) silenced_next = 1'b1;
        alarm_out_next = (alarm_ringing & alarm_armed_next & ~silenced_next) | snooze_force;
    end

    always_ff @(posedge clock_sec or posedge reset) begin
        if (reset) begin
            btn_prev_reg        <= 3'b000;
            set_time_reg        <= 1'b0;
            stopwatch_reset_reg <= 1'b0;
            stopwatch_on_reg    <= 1'b0;
            set_hour_reg        <= 4'd12;
            set_minute_reg      <= 6'd0;
            set_am_pm_reg       <= 1'b0;
            alarm_hour_reg      <= 4'd12;
            alarm_minute_reg    <= 6'd0;
            alarm_am_pm_reg     <= 1'b0;
            alarm_armed_reg     <= 1'b0;
            silenced_reg        <= 1'b0;
            alarm_out_reg       <= 1'b0;
        end else begin
            btn_prev_reg        <= btn_vec;
            set_time_reg        <= edit_min & mode_press;
            stopwatch_reset_reg <= in_sw & clr_act;
            alarm_armed_reg     <= alarm_armed_next;
            silenced_reg        <= silenced_next;
            alarm_out_reg       <= alarm_out_next;

            if (in_run && mode_press) begin
                set_hour_reg   <= cur_hours;
                set_minute_reg <= cur_minutes;
                set_am_pm_reg  <= cur_am_pm;
            end
            if (edit_hr && inc_act) begin
                set_hour_reg <= next_hour(set_hour_reg);
                if (set_hour_reg == 4'd11) set_am_pm_reg <= ~set_am_pm_reg;
            end
            if (edit_min && inc_act) set_minute_reg <= next_minute(set_minute_reg);
            if ((edit_hr || edit_min) && clr_act) set_minute_reg <= 6'd0;

            if (edit_alm_hr && inc_act) begin
                alarm_hour_reg <= next_hour(alarm_hour_reg);
                if (alarm_hour_reg == 4'd11) alarm_am_pm_reg <= ~alarm_am_pm_reg;
            end
            if (edit_alm_min && inc_act) alarm_minute_reg <= next_minute(alarm_minute_reg);
            if ((edit_alm_hr || edit_alm_min) && clr_act) alarm_minute_reg <= 6'd0;

            if (in_sw && clr_act)      stopwatch_on_reg <= 1'b0;
            else if (in_sw && inc_act) stopwatch_on_reg <= ~stopwatch_on_reg;
        end
    end

    assign set_time        = set_time_reg;
    assign set_hour        = set_hour_reg;
    assign set_minute      = set_minute_reg;
    assign set_am_pm       = set_am_pm_reg;
    assign alarm_hour      = alarm_hour_reg;
    assign alarm_minute    = alarm_minute_reg;
    assign alarm_am_pm     = alarm_am_pm_reg;
    assign stopwatch_on    = stopwatch_on_reg;
    assign stopwatch_reset = stopwatch_reset_reg;
    assign alarm_armed     = alarm_armed_reg;
    assign alarm_out       = alarm_out_reg;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: edit flow, stopwatch, alarm gating
// and mid-edit reset; snooze expectations follow the SNOOZE_EN build macro.
module tb_clock_mode_controller;

    logic       clock_sec, reset;
    logic       btn_mode, btn_inc, btn_clr;
    logic [3:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       cur_am_pm, alarm_ringing;
    logic       set_time, set_am_pm, alarm_am_pm;
    logic [3:0] set_hour, alarm_hour;
    logic [5:0] set_minute, alarm_minute;
    logic       stopwatch_on, stopwatch_reset, alarm_armed, alarm_out;
    logic [2:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    clock_mode_controller dut (
        .clock_sec       (clock_sec),
        .reset           (reset),
        .btn_mode        (btn_mode),
        .btn_inc         (btn_inc),
        .btn_clr         (btn_clr),
        .cur_hours       (cur_hours),
        .cur_minutes     (cur_minutes),
        .cur_am_pm       (cur_am_pm),
        .alarm_ringing   (alarm_ringing),
        .set_time        (set_time),
        .set_hour        (set_hour),
        .set_minute      (set_minute),
        .set_am_pm       (set_am_pm),
        .alarm_hour      (alarm_hour),
        .alarm_minute    (alarm_minute),
        .alarm_am_pm     (alarm_am_pm),
        .stopwatch_on    (stopwatch_on),
        .stopwatch_reset (stopwatch_reset),
        .mode            (mode),
        .alarm_armed     (alarm_armed),
        .alarm_out       (alarm_out)
    );

    initial begin
        clock_sec = 1'b0;
        forever #5 clock_sec = ~clock_sec;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock_sec);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i, input logic c);
        btn_mode = m;
        btn_inc  = i;
        btn_clr  = c;
        tick();
    endtask

    task automatic rel();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_clr  = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
        cur_hours = 4'd3; cur_minutes = 6'd45; cur_am_pm = 1'b1;
        alarm_ringing = 1'b0;
        #12;
        check("rst_mode", 16'(mode), 16'd0);
        check("rst_set_hour", 16'(set_hour), 16'd12);
        check("rst_set_minute", 16'(set_minute), 16'd0);
        check("rst_alarm_hour", 16'(alarm_hour), 16'd12);
        check("rst_set_time", 16'(set_time), 16'd0);
        check("rst_alarm_armed", 16'(alarm_armed), 16'd0);
        check("rst_alarm_out", 16'(alarm_out), 16'd0);
        @(negedge clock_sec);
        reset = 1'b0;
        tick();

        // Enter edit: snapshot of 3:45 PM
        pulse(1, 0, 0);
        check("enter_mode", 16'(mode), 16'd1);
        check("enter_hour", 16'(set_hour), 16'd3);
        check("enter_minute", 16'(set_minute), 16'd45);
        check("enter_am_pm", 16'(set_am_pm), 16'd1);
        rel();
        btn_inc = 1'b1;
        tick(); tick(); tick();
        check("held_inc_once", 16'(set_hour), 16'd4);
        rel();
        pulse(0, 0, 1);
        check("clr_minute_hr_edit", 16'(set_minute), 16'd0);
        rel();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        cur_hours = 4'd11; cur_minutes = 6'd59; cur_am_pm = 1'b0;
        pulse(1, 0, 0);
        check("enter2_hour", 16'(set_hour), 16'd11);
        check("enter2_am_pm", 16'(set_am_pm), 16'd0);
        rel();
        pulse(0, 1, 0);
        check("hour_11_to_12", 16'(set_hour), 16'd12);
        check("am_pm_toggle", 16'(set_am_pm), 16'd1);
        rel();
        pulse(0, 1, 0);
        check("hour_12_to_1", 16'(set_hour), 16'd1);
        check("am_pm_hold", 16'(set_am_pm), 16'd1);
        rel();
        pulse(1, 0, 0);
        check("mode_edit_min", 16'(mode), 16'd2);
        rel();
        pulse(0, 1, 0);
        check("minute_wrap", 16'(set_minute), 16'd0);
        check("minute_no_carry", 16'(set_hour), 16'd1);
        rel();
        pulse(1, 0, 0);
        check("set_time_pulse", 16'(set_time), 16'd1);
        check("mode_alm_hour", 16'(mode), 16'd3);
        rel();
        check("set_time_one_cycle", 16'(set_time), 16'd0);

        pulse(0, 1, 0);
        check("alarm_hour_inc", 16'(alarm_hour), 16'd1);
        check("alarm_am_pm_hold", 16'(alarm_am_pm), 16'd0);
        rel();
        pulse(1, 0, 0);
        check("mode_alm_min", 16'(mode), 16'd4);
        rel();
        pulse(0, 1, 0); rel();
        pulse(0, 1, 0);
        check("alarm_minute_inc", 16'(alarm_minute), 16'd2);
        rel();
        pulse(0, 0, 1);
        check("alarm_minute_clr", 16'(alarm_minute), 16'd0);
        rel();

        pulse(1, 0, 0);
        check("mode_stopwatch", 16'(mode), 16'd5);
        rel();
        pulse(0, 1, 0);
        check("sw_on", 16'(stopwatch_on), 16'd1);
        rel();
        pulse(0, 0, 1);
        check("sw_reset_pulse", 16'(stopwatch_reset), 16'd1);
        check("sw_cleared", 16'(stopwatch_on), 16'd0);
        rel();
        check("sw_reset_one_cycle", 16'(stopwatch_reset), 16'd0);
        pulse(0, 1, 0); rel();
        pulse(1, 1, 0);
        check("mode_priority", 16'(mode), 16'd0);
        check("sw_background", 16'(stopwatch_on), 16'd1);
        rel();

        // Alarm gating in RUN
        pulse(0, 0, 1);
        check("armed", 16'(alarm_armed), 16'd1);
        rel();
        alarm_ringing = 1'b1;
        tick();
        check("alarm_out_ring", 16'(alarm_out), 16'd1);
        pulse(0, 1, 0);
        check("alarm_silenced", 16'(alarm_out), 16'd0);
        rel();
        repeat (298) tick();
        check("snooze_still_quiet", 16'(alarm_out), 16'd0);
        tick();
`ifdef SNOOZE_EN
        check("snooze_reringing", 16'(alarm_out), 16'd1);
`else
        check("silence_holds", 16'(alarm_out), 16'd0);
`endif
        pulse(0, 0, 1);
        check("disarm", 16'(alarm_armed), 16'd0);
        check("disarm_quiet", 16'(alarm_out), 16'd0);
        rel();
        alarm_ringing = 1'b0;
        tick();
        alarm_ringing = 1'b1;
        tick();
        check("disarmed_ring", 16'(alarm_out), 16'd0);
        pulse(0, 0, 1);
        check("rearm_ring", 16'(alarm_out), 16'd1);
        rel();
        alarm_ringing = 1'b0;
        tick();
        check("ring_stops", 16'(alarm_out), 16'd0);

        // Reset in the middle of EDIT_MIN
        pulse(1, 0, 0); rel();
        pulse(1, 0, 0); rel();
        check("pre_reset_edit_min", 16'(mode), 16'd2);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_mode", 16'(mode), 16'd0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("no_set_time_%0d", k), 16'(set_time), 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
